hbm_perf_monitor: RTL

//  Parametrised multi-port HBM traffic monitor; successor to the single-port bench monitor bundle.

---
 rtl/hbm_mon_pkg.sv | 24 ++
 rtl/hbm_mon_sat_counter.sv | 39 +++
 rtl/hbm_perf_monitor.sv | 137 +++++++++++++
 3 files changed

// File: rtl/hbm_mon_pkg.sv
// Shared types and helpers for the multi-port HBM traffic monitor.
// The port-count bound and the popcount width are sized for the 32-port maximum.
package hbm_mon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mon_state_t;

    localparam int STATE_W   = 2;
    localparam int MAX_PORTS = 32;
    localparam int PCNT_W    = 6;

    function automatic logic [PCNT_W-1:0] popcount(input logic [MAX_PORTS-1:0] v);
        logic [PCNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < MAX_PORTS; i++) begin
            n = n + PCNT_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/hbm_mon_sat_counter.sv
// Clearable event counter that clamps at all-ones instead of wrapping.
// The sum is formed one bit wider than the wider operand so an overflowing add is caught.
module hbm_mon_sat_counter #(
    parameter int W     = 36,
    parameter int INC_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [INC_W-1:0] inc,
    output logic [W-1:0]     q,
    output logic             sat
);

    localparam int SUM_W = ((W > INC_W) ? W : INC_W) + 1;
    localparam logic [SUM_W-1:0] MAX_V = {{(SUM_W-W){1'b0}}, {W{1'b1}}};

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = SUM_W'(q) + SUM_W'(inc);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q   <= '0;
            sat <= 1'b0;
        end else if (en) begin
            if (sum >= MAX_V) begin
                q   <= '1;
                sat <= 1'b1;
            end else begin
                q <= sum[W-1:0];
            end
        end
    end

endmodule

// File: rtl/hbm_perf_monitor.sv
// Multi-port HBM traffic monitor: windowed per-port beat/response counters,
// aggregate totals and a registered per-port readout for VIO/ILA capture.
module hbm_perf_monitor
    import hbm_mon_pkg::*;
#(
    parameter int NUM_PORTS = 32,
    parameter int CNT_W     = 36,
    parameter int WIN_W     = 32,
    parameter int SEL_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [WIN_W-1:0]     window_len,
    input  logic [NUM_PORTS-1:0] wnext,
    input  logic [NUM_PORTS-1:0] rokay,
    input  logic [NUM_PORTS-1:0] rerr,
    input  logic [NUM_PORTS-1:0] bokay,
    input  logic [NUM_PORTS-1:0] berr,
    input  logic [SEL_W-1:0]     sel_port,
    output logic [STATE_W-1:0]   state,
    output logic                 done,
    output logic [WIN_W-1:0]     elapsed,
    output logic [CNT_W-1:0]     count_wnext,
    output logic [CNT_W-1:0]     count_rokay,
    output logic [CNT_W-1:0]     count_bokay,
    output logic [CNT_W-1:0]     count_err,
    output logic [CNT_W-1:0]     total_wnext,
    output logic [CNT_W-1:0]     total_rokay,
    output logic [NUM_PORTS-1:0] saturated
);

    localparam int SEL_N = 2 ** SEL_W;

    mon_state_t       state_q, state_d;
    logic [WIN_W-1:0] win_len_q;
    logic             count_en;

    // Events on the start cycle are dropped; that cycle only clears.
    assign count_en = (state_q == RUN) && !start;
    assign state    = state_q;

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = RUN;
        end else if (state_q == RUN) begin
            if (stop || (win_len_q != '0 && elapsed == win_len_q - WIN_W'(1))) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            done      <= 1'b0;
            win_len_q <= '0;
            elapsed   <= '0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == DONE) && (state_q != DONE);
            if (start) begin
                win_len_q <= window_len;
                elapsed   <= '0;
            end else if (count_en && elapsed != '1) begin
                elapsed <= elapsed + WIN_W'(1);
            end
        end
    end

    // Counter arrays span the full select range; slots past NUM_PORTS read as zero.
    logic [CNT_W-1:0] cnt_w [SEL_N];
    logic [CNT_W-1:0] cnt_r [SEL_N];
    logic [CNT_W-1:0] cnt_b [SEL_N];
    logic [CNT_W-1:0] cnt_e [SEL_N];

    for (genvar p = 0; p < SEL_N; p++) begin : g_port
        if (p < NUM_PORTS) begin : g_live
            logic sat_w, sat_r, sat_b, sat_e;

            hbm_mon_sat_counter #(.W(CNT_W), .INC_W(2)) u_cnt_w (
                .clk(clk), .rst(rst), .clr(start), .en(count_en),
                .inc({1'b0, wnext[p]}), .q(cnt_w[p]), .sat(sat_w)
            );
            hbm_mon_sat_counter #(.W(CNT_W), .INC_W(2)) u_cnt_r (
                .clk(clk), .rst(rst), .clr(start), .en(count_en),
                .inc({1'b0, rokay[p]}), .q(cnt_r[p]), .sat(sat_r)
            );
            hbm_mon_sat_counter #(.W(CNT_W), .INC_W(2)) u_cnt_b (
                .clk(clk), .rst(rst), .clr(start), .en(count_en),
                .inc({1'b0, bokay[p]}), .q(cnt_b[p]), .sat(sat_b)
            );
            // rerr and berr together add two.
            hbm_mon_sat_counter #(.W(CNT_W), .INC_W(2)) u_cnt_e (
                .clk(clk), .rst(rst), .clr(start), .en(count_en),
                .inc({rerr[p] & berr[p], rerr[p] ^ berr[p]}), .q(cnt_e[p]), .sat(sat_e)
            );

            assign saturated[p] = sat_w | sat_r | sat_b | sat_e;
        end else begin : g_pad
            assign cnt_w[p] = '0;
            assign cnt_r[p] = '0;
            assign cnt_b[p] = '0;
            assign cnt_e[p] = '0;
        end
    end

    logic unused_tot_w_sat;
    logic unused_tot_r_sat;

    hbm_mon_sat_counter #(.W(CNT_W), .INC_W(PCNT_W)) u_tot_w (
        .clk(clk), .rst(rst), .clr(start), .en(count_en),
        .inc(popcount(MAX_PORTS'(wnext))), .q(total_wnext), .sat(unused_tot_w_sat)
    );
    hbm_mon_sat_counter #(.W(CNT_W), .INC_W(PCNT_W)) u_tot_r (
        .clk(clk), .rst(rst), .clr(start), .en(count_en),
        .inc(popcount(MAX_PORTS'(rokay))), .q(total_rokay), .sat(unused_tot_r_sat)
    );

    // Readout register stage: one cycle behind the live counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_wnext <= '0;
            count_rokay <= '0;
            count_bokay <= '0;
            count_err   <= '0;
        end else begin
            count_wnext <= cnt_w[sel_port];
            count_rokay <= cnt_r[sel_port];
            count_bokay <= cnt_b[sel_port];
            count_err   <= cnt_e[sel_port];
        end
    end

endmodule
